mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Multi-cycle main control FSM for the 32-bit MIPS core. It decodes the IR opcode and sequences
//  the datapath through fetch, decode and execute steps. It is the driver of the ALU-op interface:
//  it generates AluOp1/AluOp0, which the ALU control decoder combines with the funct field.
//  Memory accesses stall on a MemReady handshake.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode (add/sub/and/or/xor via funct)
//  OP_LW     6'b100011  load word
//  OP_SW     6'b101011  store word
//  OP_BEQ    6'b000100  branch if equal
//  OP_J      6'b000010  jump
//  OP_ORI    6'b001101  OR immediate
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  synchronous reset, active low
//  Opcode       in   6  IR[31:26]; sampled only in DECODE
//  MemReady     in   1  memory finished the current read/write this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if ALU Zero
//  IorD         out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  load IR
//  MemtoReg     out  1  register-file write data: 1 = MDR, 0 = ALUOut
//  RegDst       out  1  register-file destination: 1 = rd, 0 = rt
//  RegWrite     out  1  register-file write enable
//  ALUSrcA      out  1  0 = PC, 1 = register A
//  ALUSrcB      out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
//  PCSource     out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
//  AluOp1       out  1  ALU-op MSB to the ALU control decoder
//  AluOp0       out  1  ALU-op LSB; {1,0}: 00 = add, 01 = sub, 10 = funct, 11 = OR
//  InstrDone    out  1  one-cycle pulse in the last state of each legal instruction
//  IllegalOp    out  1  one-cycle pulse in DECODE for an unknown opcode
//  State        out  4  current state encoding, for debug
// BEHAVIOUR
//  - Moore outputs, decoded combinationally from the state register. Outputs not listed for a state are 0.
//  - Reset: when rst_n=0 at a clk edge, state <= IDLE(0); every output is 0 and State=0.
//    Reset overrides any state, including a stalled memory access.
//  - IDLE(0): all outputs 0; next state FETCH.
//  - FETCH(1): MemRead=1, ALUSrcB=01, AluOp=00.
//    If MemReady=1: IRWrite=1, PCWrite=1, next DECODE. Otherwise hold FETCH with IRWrite=PCWrite=0.
//  - DECODE(2): ALUSrcB=11, AluOp=00. Next state by opcode:
//    LW/SW -> MEMADR, RTYPE -> EXEC, BEQ -> BRANCH, J -> JUMP, ORI -> IEXEC.
//    Any other opcode: IllegalOp=1, next FETCH, no InstrDone.
//  - MEMADR(3): ALUSrcA=1, ALUSrcB=10, AluOp=00; next MEMRD for LW, MEMWR for SW.
//  - MEMRD(4): MemRead=1, IorD=1; hold until MemReady=1, then MEMWB.
//  - MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1; next FETCH.
//  - MEMWR(6): MemWrite=1, IorD=1; hold while MemReady=0.
//    When MemReady=1: InstrDone=1, next FETCH.
//  - EXEC(7): ALUSrcA=1, ALUSrcB=00, AluOp=10; next RCOMP.
//  - RCOMP(8): RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1; next FETCH.
//  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01, InstrDone=1; next FETCH.
//  - JUMP(10): PCWrite=1, PCSource=10, InstrDone=1; next FETCH.
//  - IEXEC(11): ALUSrcA=1, ALUSrcB=10, AluOp=11; next ICOMP.
//  - ICOMP(12): RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1; next FETCH.
//  - Encodings 13-15 are unreachable; if entered, all outputs are 0 and next state is FETCH.
//  - Latency with MemReady tied to 1, in clocks from FETCH to the InstrDone cycle inclusive:
//    LW 5, SW 4, R-type 4, ORI 4, BEQ 3, J 3.
//  - Each cycle MemReady is held low in FETCH, MEMRD or MEMWR adds exactly one clock.
//  - MemReady is ignored in every state other than FETCH, MEMRD and MEMWR.
//  - Opcode is ignored outside DECODE.
// TESTING
//  1. rst_n=0 for 2 clks, then 1 -> State 0 then 1 on the next edge; all outputs 0 while in reset and in IDLE.
//  2. Opcode=100011, MemReady=1 -> State 1,2,3,4,5.
//     AluOp=00 in FETCH and MEMADR; MemtoReg=RegWrite=InstrDone=1 in state 5.
//  3. Opcode=000000 -> State 7 with {AluOp1,AluOp0}=10, then state 8 with RegDst=RegWrite=1.
//     Opcode=000100 -> State 9 with AluOp=01 and PCWriteCond=1.
//  4. Opcode=101011, MemReady=0 for 3 clks in MEMWR -> state 6 held 4 clks with MemWrite=1; InstrDone only on the ready clk.
//  5. Opcode=111111 -> IllegalOp=1 for one clk in DECODE, next State=1, InstrDone never asserted.
//  6. rst_n=0 while stalled in MEMRD -> State=0 on the next edge with MemRead=0.
//     Opcode=001101 afterwards -> State 11 with AluOp=11, then state 12 with RegWrite=1.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: control bundle between the main FSM (master) and the datapath (slave)
interface mips_multicycle_control_if;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       AluOp1;
    logic       AluOp0;
    logic       InstrDone;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, AluOp1, AluOp0, InstrDone, IllegalOp, State
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, AluOp1, AluOp0, InstrDone, IllegalOp, State
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle MIPS main control FSM with MemReady stalls
module mips_multicycle_control (
    input logic                        clk,
    input logic                        rst_n,
    mips_multicycle_control_if.master  bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        RCOMP  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        IEXEC  = 4'd11,
        ICOMP  = 4'd12
    } state_t;

    state_t state_q, state_d;
    // Opcode is only valid in DECODE, so MEMADR needs the load/store choice remembered
    logic   is_sw_q, is_sw_d;

    always_comb begin
        state_d         = FETCH;
        is_sw_d         = (state_q == DECODE) ? (bus.Opcode == OP_SW) : is_sw_q;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.AluOp1      = 1'b0;
        bus.AluOp0      = 1'b0;
        bus.InstrDone   = 1'b0;
        bus.IllegalOp   = 1'b0;
        bus.State       = state_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
                state_d     = bus.MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                bus.ALUSrcB   = 2'b11;
                state_d       = (bus.Opcode == OP_LW || bus.Opcode == OP_SW) ? MEMADR :
                                (bus.Opcode == OP_RTYPE) ? EXEC :
                                (bus.Opcode == OP_BEQ)   ? BRANCH :
                                (bus.Opcode == OP_J)     ? JUMP :
                                (bus.Opcode == OP_ORI)   ? IEXEC : FETCH;
                bus.IllegalOp = (state_d == FETCH);
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = is_sw_q ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                state_d     = bus.MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                bus.RegWrite  = 1'b1;
                bus.MemtoReg  = 1'b1;
                bus.InstrDone = 1'b1;
            end
            MEMWR: begin
                bus.MemWrite  = 1'b1;
                bus.IorD      = 1'b1;
                bus.InstrDone = bus.MemReady;
                state_d       = bus.MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.AluOp1  = 1'b1;
                state_d     = RCOMP;
            end
            RCOMP: begin
                bus.RegWrite  = 1'b1;
                bus.RegDst    = 1'b1;
                bus.InstrDone = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.AluOp0      = 1'b1;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.InstrDone   = 1'b1;
            end
            JUMP: begin
                bus.PCWrite   = 1'b1;
                bus.PCSource  = 2'b10;
                bus.InstrDone = 1'b1;
            end
            IEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.AluOp1  = 1'b1;
                bus.AluOp0  = 1'b1;
                state_d     = ICOMP;
            end
            ICOMP: begin
                bus.RegWrite  = 1'b1;
                bus.InstrDone = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: randomized and directed checks of the multi-cycle MIPS control FSM
module tb_mips_multicycle_control;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic last_done;

    mips_multicycle_control_if b ();
    mips_multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(b));

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {b.PCWrite, b.PCWriteCond, b.IorD, b.MemRead, b.MemWrite, b.IRWrite, b.MemtoReg,
                  b.RegDst, b.RegWrite, b.ALUSrcA, b.ALUSrcB, b.PCSource, b.AluOp1, b.AluOp0,
                  b.InstrDone, b.IllegalOp};

    // Control word each state must present, straight from the state table
    function automatic logic [17:0] exp_out(int st, bit r);
        logic pcw = 0, pcc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0;
        logic sa = 0, a1 = 0, a0 = 0, dn = 0, il = 0;
        logic [1:0] sb = 0, ps = 0;
        case (st)
            1:  begin mr = 1; sb = 2'b01; irw = r; pcw = r; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mr = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; dn = 1; end
            6:  begin mw = 1; iord = 1; dn = r; end
            7:  begin sa = 1; a1 = 1; end
            8:  begin rw = 1; rd = 1; dn = 1; end
            9:  begin sa = 1; a0 = 1; pcc = 1; ps = 2'b01; dn = 1; end
            10: begin pcw = 1; ps = 2'b10; dn = 1; end
            11: begin sa = 1; sb = 2'b10; a1 = 1; a0 = 1; end
            12: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, a1, a0, dn, il};
    endfunction

    function automatic int latency(logic [5:0] op);
        case (op)
            OP_LW:                     return 5;
            OP_SW, OP_RTYPE, OP_ORI:   return 4;
            OP_BEQ, OP_J:              return 3;
            default:                   return 0;
        endcase
    endfunction

    // One clock: drive inputs, check at negedge, advance to just after the next rising edge
    task automatic step(int st, bit r, logic [5:0] op, bit ill);
        logic [17:0] e;
        b.MemReady = r;
        b.Opcode   = op;
        @(negedge clk);
        e = exp_out(st, r) | {17'b0, ill};
        vectors++;
        if (b.State !== st[3:0]) begin
            miscompares++;
            $display("FAIL state: got %0d expected %0d (t=%0t)", b.State, st, $time);
        end
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL outputs st%0d: got %b expected %b (t=%0t)", st, obs, e, $time);
        end
        last_done = b.InstrDone;
        @(posedge clk);
        #1;
    endtask

    // Expected state walk of one instruction starting in FETCH, with chosen stall counts
    task automatic run_instr(logic [5:0] op, int f, int m);
        int  sq[$];
        bit  rq[$];
        int  done_at = -1;
        int  mm;
        int  exp_at;
        for (int i = 0; i < f; i++) begin sq.push_back(1); rq.push_back(0); end
        sq.push_back(1); rq.push_back(1);
        sq.push_back(2); rq.push_back(1'($urandom));
        mm = (op == OP_LW || op == OP_SW) ? m : 0;
        case (op)
            OP_LW: begin
                sq.push_back(3); rq.push_back(1'($urandom));
                for (int i = 0; i < m; i++) begin sq.push_back(4); rq.push_back(0); end
                sq.push_back(4); rq.push_back(1);
                sq.push_back(5); rq.push_back(1'($urandom));
            end
            OP_SW: begin
                sq.push_back(3); rq.push_back(1'($urandom));
                for (int i = 0; i < m; i++) begin sq.push_back(6); rq.push_back(0); end
                sq.push_back(6); rq.push_back(1);
            end
            OP_RTYPE: begin
                sq.push_back(7); rq.push_back(1'($urandom));
                sq.push_back(8); rq.push_back(1'($urandom));
            end
            OP_BEQ: begin sq.push_back(9); rq.push_back(1'($urandom)); end
            OP_J:   begin sq.push_back(10); rq.push_back(1'($urandom)); end
            OP_ORI: begin
                sq.push_back(11); rq.push_back(1'($urandom));
                sq.push_back(12); rq.push_back(1'($urandom));
            end
            default: ;
        endcase
        for (int i = 0; i < sq.size(); i++) begin
            step(sq[i], rq[i], (sq[i] == 2) ? op : 6'($urandom), sq[i] == 2 && latency(op) == 0);
            if (last_done === 1'b1 && done_at < 0) done_at = i;
        end
        exp_at = (latency(op) == 0) ? -1 : latency(op) + f + mm - 1;
        vectors++;
        if (done_at != exp_at) begin
            miscompares++;
            $display("FAIL latency op=%b: InstrDone at cycle %0d expected %0d", op, done_at, exp_at);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b.MemReady = 1'b1;
        b.Opcode = 6'($urandom);
        repeat (2) @(posedge clk);
        #1;
        step(0, 1, 6'($urandom), 0);
        rst_n = 1'b1;
        step(0, 1, 6'($urandom), 0);
    endtask

    task automatic test_lw();           run_instr(OP_LW, 0, 0); endtask
    task automatic test_rtype_beq();    run_instr(OP_RTYPE, 0, 0); run_instr(OP_BEQ, 0, 0); endtask
    task automatic test_sw_stall();     run_instr(OP_SW, 0, 3); endtask
    task automatic test_illegal();      run_instr(6'b111111, 0, 0); endtask
    task automatic test_jump_fetch_stall(); run_instr(OP_J, 2, 0); run_instr(OP_LW, 1, 2); endtask

    task automatic test_reset_in_memrd();
        step(1, 1, 6'($urandom), 0);
        step(2, 1, OP_LW, 0);
        step(3, 1, 6'($urandom), 0);
        step(4, 0, 6'($urandom), 0);
        rst_n = 1'b0;
        step(4, 0, 6'($urandom), 0);
        step(0, 0, 6'($urandom), 0);
        rst_n = 1'b1;
        step(0, 0, 6'($urandom), 0);
        run_instr(OP_ORI, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        logic [5:0] op;
        ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
        ops[4] = OP_J; ops[5] = OP_ORI; ops[6] = 6'b000000;
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_beq();
        test_sw_stall();
        test_illegal();
        test_jump_fetch_stall();
        test_reset_in_memrd();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
